fifo_ctrl_dp: RTL and testbench
===============================

// Module: fifo_ctrl_dp
// PURPOSE
//  Synchronous FIFO controller wrapped around the dual-port async-read RAM.
//  Turns a valid/ready producer stream into RAM write-port cycles (addr/data/we).
//  Drives the RAM read address and returns RAM read data to a valid/ready consumer.
//  Sits directly upstream of the RAM write port and downstream of its read port.
// PARAMETERS
//  WIDTH      8              data word width; must match the RAM WIDTH
//  DEPTH      16             entry count; power of 2, >=2; must match the RAM DEPTH
//  DEPTH_LOG  $clog2(DEPTH)  RAM address width
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          synchronous reset, active-high
//  flush        in   1          synchronous clear of all entries
//  wr_valid     in   1          producer presents wr_data
//  wr_ready     out  1          FIFO can accept (= !full)
//  wr_data      in   WIDTH      producer data
//  rd_valid     out  1          head entry available (= !empty)
//  rd_ready     in   1          consumer takes head entry
//  rd_data      out  WIDTH      head entry (= ram_rd_data, combinational)
//  count        out  DEPTH_LOG+1 number of stored entries, 0..DEPTH
//  ram_we       out  1          RAM write enable, active-high, to RAM write-enable pin
//  ram_addr_wr  out  DEPTH_LOG  RAM write address
//  ram_addr_rd  out  DEPTH_LOG  RAM read address
//  ram_data_wr  out  WIDTH      RAM write data
//  ram_rd_data  in   WIDTH      RAM async read data
// BEHAVIOUR
//  - Pointers wr_ptr/rd_ptr are DEPTH_LOG+1 bits; the MSB is the wrap bit.
//    empty = (wr_ptr == rd_ptr); full = (addr bits equal, wrap bits differ).
//  - push = wr_valid & wr_ready; pop = rd_valid & rd_ready. Both are evaluated on
//    the same edge, against registered pointers.
//  - ram_we = push (combinational); ram_addr_wr = wr_ptr[DEPTH_LOG-1:0];
//    ram_data_wr = wr_data. The RAM captures the word on the push edge.
//  - ram_addr_rd = rd_ptr[DEPTH_LOG-1:0]; rd_data = ram_rd_data (no added latency).
//  - Latency: a word pushed at edge N is visible (rd_valid=1) after edge N, so
//    pop is possible from cycle N+1 onward. There is no bypass on an empty FIFO.
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//    count == wr_ptr - rd_ptr (mod 2^(DEPTH_LOG+1)).
//  - Full: wr_ready=0, so push is blocked even if a pop occurs in the same cycle.
//    That pop still completes; the next cycle has wr_ready=1.
//  - Empty: rd_valid=0, so pop is ignored; rd_data is don't-care.
//  - Simultaneous push and pop (neither full nor empty): both pointers advance
//    and count holds.
//  - Wrap-around: the addr bits roll DEPTH-1 -> 0 and the wrap bit toggles.
//  - rst, or flush: next edge sets wr_ptr=rd_ptr=0 and count=0. This gives
//    wr_ready=1 and rd_valid=0. Any push/pop in that cycle is discarded, with
//    ram_we forced 0. RAM contents are not cleared.
//  - Reset mid-stream drops all stored words with no partial state kept.
//  - Reset values: wr_ready=1, rd_valid=0, count=0, ram_we=0, ram_addr_wr=0,
//    ram_addr_rd=0.
// CONFIGURATION
//  FIFO_CTRL_ERR_EN defined: adds outputs ovf (1) and udf (1).
//    - Sticky flags, reset to 0 by rst or flush.
//    - ovf sets when wr_valid=1 while full.
//    - udf sets when rd_ready=1 while empty.
//    - Flags assert the edge after the offending cycle.
//  FIFO_CTRL_ERR_EN undefined: no ovf/udf ports and no flag logic. All other
//    behaviour is identical.
// TESTING  (bench instantiates fifo_ctrl_dp + RAM, WIDTH=8, DEPTH=16)
//  1. Reset, then push 0x00..0x0F back-to-back -> count 1..16, wr_ready=0 after
//     the 16th, rd_valid=1; pop all 16 -> rd_data 0x00..0x0F in order, then
//     rd_valid=0, count=0.
//  2. Full FIFO + wr_valid=1, rd_ready=1 same cycle -> pop of the head only,
//     count 15, the blocked word is not written; next cycle the push is accepted,
//     count 16.
//  3. Steady push+pop for 40 cycles starting at count 3 -> count stays 3, data
//     order is preserved across pointer wrap (addr 15 -> 0).
//  4. Push 0xA5 into empty FIFO -> rd_valid=0 in the push cycle, rd_valid=1 and
//     rd_data=0xA5 the next cycle.
//  5. Load 9 words, assert flush with wr_valid=1 -> next cycle count=0,
//     rd_valid=0, wr_ready=1, ram_we was 0; repeat with rst -> same result.
//  6. FIFO_CTRL_ERR_EN: push into full -> ovf=1 next cycle and held; pop from
//     empty -> udf=1; flush -> both 0.

Source files
------------

// File: rtl/fifo_ctrl_dp.sv
// Purpose: FIFO controller around a dual-port async-read RAM; write port from valid/ready producer, read port to consumer.
// Latency: a word pushed on edge N is poppable from cycle N+1; read data is combinational from the RAM (no bypass when empty).
// Backpressure: wr_ready = !full (a same-cycle pop does not unblock), rd_valid = !empty; optional ovf/udf under FIFO_CTRL_ERR_EN.
module fifo_ctrl_dp #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic [DEPTH_LOG:0]   count,
  output logic                 ram_we,
  output logic [DEPTH_LOG-1:0] ram_addr_wr,
  output logic [DEPTH_LOG-1:0] ram_addr_rd,
  output logic [WIDTH-1:0]     ram_data_wr,
  input  logic [WIDTH-1:0]     ram_rd_data
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic                 ovf,
  output logic                 udf
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH_LOG:0] wr_ptr;
  logic [DEPTH_LOG:0] rd_ptr;
  logic [DEPTH_LOG:0] count_q;
  logic               empty;
  logic               full;
  logic               clear;
  logic               push;
  logic               pop;

  // Status and handshake decode from registered pointers only.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]) &&
            (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]);
    clear = rst | flush;
    wr_ready = !full;
    rd_valid = !empty;
    // A clearing cycle discards any transfer so the RAM is never written.
    push = wr_valid & wr_ready & !clear;
    pop  = rd_valid & rd_ready & !clear;
  end

  // RAM port drive: write port follows the tail, read port follows the head.
  always_comb begin
    ram_we      = push;
    ram_addr_wr = wr_ptr[DEPTH_LOG-1:0];
    ram_data_wr = wr_data;
    ram_addr_rd = rd_ptr[DEPTH_LOG-1:0];
    rd_data     = ram_rd_data;
    count       = count_q;
  end

  // Pointer and occupancy update; clear wins over any transfer.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (DEPTH_LOG+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (DEPTH_LOG+1)'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (DEPTH_LOG+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  // Sticky error flags: attempted write while full, attempted read while empty.
  always_ff @(posedge clk) begin
    if (clear) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_valid && full) ovf <= 1'b1;
      if (rd_ready && empty) udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// Bench for fifo_ctrl_dp with a behavioural dual-port async-read RAM.
// Directed steps; a queue scoreboard holds pushed words and checks them on pop.
// FIFO_CTRL_ERR_EN builds also exercise the sticky ovf/udf flags.
module tb_fifo_ctrl_dp;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int DL    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [DL:0]      count;
  logic             ram_we;
  logic [DL-1:0]    ram_addr_wr;
  logic [DL-1:0]    ram_addr_rd;
  logic [WIDTH-1:0] ram_data_wr;
  logic [WIDTH-1:0] ram_rd_data;
`ifdef FIFO_CTRL_ERR_EN
  logic             ovf;
  logic             udf;
`endif

  always #5 clk = ~clk;

  fifo_ctrl_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .ram_we(ram_we), .ram_addr_wr(ram_addr_wr),
    .ram_addr_rd(ram_addr_rd), .ram_data_wr(ram_data_wr),
    .ram_rd_data(ram_rd_data)
`ifdef FIFO_CTRL_ERR_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  // Behavioural RAM: synchronous write, asynchronous read.
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (ram_we) mem[ram_addr_wr] <= ram_data_wr;
  assign ram_rd_data = mem[ram_addr_rd];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state.
  logic [WIDTH-1:0] sb [$];
  logic [DL:0]      m_wptr;
  logic [DL:0]      m_rptr;
  logic             m_ovf;
  logic             m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, update model.
  task automatic cycle(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
    logic m_full, m_empty, m_clr, m_push, m_pop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #2;
    m_full  = (sb.size() == DEPTH);
    m_empty = (sb.size() == 0);
    m_clr   = rst | flush;
    m_push  = wv && !m_full && !m_clr;
    m_pop   = rr && !m_empty && !m_clr;
    chk("wr_ready", 32'(wr_ready), 32'(!m_full));
    chk("rd_valid", 32'(rd_valid), 32'(!m_empty));
    chk("count", 32'(count), 32'(sb.size()));
    chk("ram_we", 32'(ram_we), 32'(m_push));
    chk("ram_addr_wr", 32'(ram_addr_wr), 32'(m_wptr[DL-1:0]));
    chk("ram_addr_rd", 32'(ram_addr_rd), 32'(m_rptr[DL-1:0]));
    if (m_push) chk("ram_data_wr", 32'(ram_data_wr), 32'(wd));
    if (m_pop)  chk("rd_data", 32'(rd_data), 32'(sb[0]));
`ifdef FIFO_CTRL_ERR_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`endif
    @(posedge clk);
    #1;
    if (m_clr) begin
      sb.delete();
      m_wptr = '0;
      m_rptr = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      if (wv && m_full)  m_ovf = 1'b1;
      if (rr && m_empty) m_udf = 1'b1;
      if (m_push) begin sb.push_back(wd); m_wptr = m_wptr + 1'b1; end
      if (m_pop)  begin void'(sb.pop_front()); m_rptr = m_rptr + 1'b1; end
    end
  endtask

  initial begin
    m_wptr = '0; m_rptr = '0; m_ovf = 1'b0; m_udf = 1'b0;
    rst = 1'b1; flush = 1'b0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state is checked by the first idle cycle; then fill to full.
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    // Full: push attempt must be refused without writing.
    cycle(1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Full + push + pop in the same cycle: only the pop completes.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    cycle(1'b1, 8'hEF, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);

    // Steady push+pop at occupancy 3 across pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Push into empty: not readable until the following cycle.
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Flush with a push pending, then the same with rst.
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    flush = 1'b1;
    cycle(1'b1, 8'h77, 1'b1);
    flush = 1'b0;
    cycle(1'b1, 8'h61, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
    rst = 1'b1;
    cycle(1'b1, 8'h88, 1'b1);
    rst = 1'b0;
    cycle(1'b1, 8'h62, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

`ifdef FIFO_CTRL_ERR_EN
    // Error flags: overflow, held through draining, underflow, cleared by flush.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b1, 8'hDD, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    flush = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    flush = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
